// File: rtl/arb_req_agent_if.sv
// Bus between the arbiter requester front end and its environment:
// client pushes, arbiter req/gnt, retired-grant events and status flags.
interface arb_req_agent_if #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   push;
  logic [NUM_REQ-1:0]   full;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic                 grant_valid;
  logic [PTR_WIDTH-1:0] grant_id;
  logic [NUM_REQ-1:0]   overflow;
  logic [NUM_REQ-1:0]   starve;
  logic                 err_gnt;
  logic                 flag_clr;

  // agent side
  modport slave (
    input  push, gnt, flag_clr,
    output full, req, grant_valid, grant_id, overflow, starve, err_gnt
  );

  // client / arbiter side
  modport master (
    output push, gnt, flag_clr,
    input  full, req, grant_valid, grant_id, overflow, starve, err_gnt
  );
endinterface

// File: rtl/arb_req_agent.sv
// Requester front end for a round-robin arbiter: per-client pending counts
// drive req, valid grants retire one transaction, grant protocol and starvation are monitored.
module arb_req_agent #(
  parameter int NUM_REQ      = 4,
  parameter int PTR_WIDTH    = $clog2(NUM_REQ),
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  arb_req_agent_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [CW-1:0]        cnt_q [NUM_REQ];
  logic [CW-1:0]        cnt_d [NUM_REQ];
  logic [SW-1:0]        sc_q  [NUM_REQ];
  logic [SW-1:0]        sc_d  [NUM_REQ];
  logic [NUM_REQ-1:0]   overflow_q, overflow_d;
  logic [NUM_REQ-1:0]   starve_q, starve_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [PTR_WIDTH-1:0] grant_id_q, grant_id_d;
  logic                 err_gnt_q, err_gnt_d;

  logic [NUM_REQ-1:0]   req_vec;
  logic [NUM_REQ-1:0]   full_vec;
  logic [PTR_WIDTH:0]   gnt_cnt;
  logic [PTR_WIDTH-1:0] gnt_idx;
  logic                 valid_gnt;
  logic                 invalid_gnt;
  logic [NUM_REQ-1:0]   vg_vec;
  logic [NUM_REQ-1:0]   accept_vec;
  logic [NUM_REQ-1:0]   drop_vec;
  logic [NUM_REQ-1:0]   starve_set_vec;

  // req/full depend only on stored counts, so no loop through the arbiter
  always_comb begin
    req_vec  = '0;
    full_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec[i]  = (cnt_q[i] != '0);
      full_vec[i] = (cnt_q[i] == DEPTH_C);
    end
  end

  always_comb begin
    gnt_cnt = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.gnt[i]) begin
        gnt_cnt = gnt_cnt + (PTR_WIDTH+1)'(1);
        gnt_idx = PTR_WIDTH'(i);
      end else begin
        gnt_cnt = gnt_cnt;
      end
    end
    valid_gnt   = (gnt_cnt == (PTR_WIDTH+1)'(1)) && ((bus.gnt & ~req_vec) == '0);
    invalid_gnt = (bus.gnt != '0) && !valid_gnt;
    if (valid_gnt) begin
      vg_vec = bus.gnt;
    end else begin
      vg_vec = '0;
    end
  end

  always_comb begin
    accept_vec     = '0;
    drop_vec       = '0;
    starve_set_vec = '0;
    overflow_d     = overflow_q;
    starve_d       = starve_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      sc_d[i]  = '0;
      // a grant in the same cycle frees the slot the push needs
      accept_vec[i] = bus.push[i] && (!full_vec[i] || vg_vec[i]);
      drop_vec[i]   = bus.push[i] && !accept_vec[i];
      if (accept_vec[i] && !vg_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!accept_vec[i] && vg_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      if (req_vec[i] && !vg_vec[i]) begin
        if (sc_q[i] == LIMIT_C) begin
          sc_d[i] = sc_q[i];
        end else begin
          sc_d[i] = sc_q[i] + SW'(1);
        end
      end else begin
        sc_d[i] = '0;
      end

      // saturated counter keeps re-raising a flag that was cleared
      starve_set_vec[i] = (sc_d[i] == LIMIT_C) && ((sc_q[i] != LIMIT_C) || !starve_q[i]);

      overflow_d[i] = (overflow_q[i] && !bus.flag_clr) || drop_vec[i];
      starve_d[i]   = (starve_q[i] && !bus.flag_clr) || starve_set_vec[i];
    end
  end

  always_comb begin
    grant_valid_d = valid_gnt;
    err_gnt_d     = invalid_gnt;
    if (valid_gnt) begin
      grant_id_d = gnt_idx;
    end else begin
      grant_id_d = grant_id_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
        sc_q[i]  <= '0;
      end
      overflow_q    <= '0;
      starve_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      err_gnt_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
        sc_q[i]  <= sc_d[i];
      end
      overflow_q    <= overflow_d;
      starve_q      <= starve_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      err_gnt_q     <= err_gnt_d;
    end
  end

  assign bus.req         = req_vec;
  assign bus.full        = full_vec;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.overflow    = overflow_q;
  assign bus.starve      = starve_q;
  assign bus.err_gnt     = err_gnt_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent: hand-computed expectations, plus a
// small round-robin arbiter model for the integration step.
module tb_arb_req_agent;

  logic       clk;
  logic       rst;
  logic [3:0] gnt_dir;
  logic       arb_mode;
  logic [1:0] last_q;
  logic [3:0] arb_gnt;
  logic [1:0] arb_idx;
  int         checks = 0;
  int         errors = 0;

  arb_req_agent_if #(.NUM_REQ(4)) bus ();

  arb_req_agent #(
    .NUM_REQ(4), .DEPTH(4), .STARVE_LIMIT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round-robin reference arbiter: search starts after the last winner
  always_comb begin
    arb_gnt = 4'b0000;
    arb_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (arb_gnt == 4'b0000 && bus.req[(int'(last_q) + k) % 4]) begin
        arb_gnt[(int'(last_q) + k) % 4] = 1'b1;
        arb_idx = 2'((int'(last_q) + k) % 4);
      end
    end
    bus.gnt = arb_mode ? arb_gnt : gnt_dir;
  end

  always @(posedge clk) begin
    if (rst) last_q <= 2'd3;
    else if (arb_mode && arb_gnt != 4'b0000) last_q <= arb_idx;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    gnt_dir      = 4'b0000;
    arb_mode     = 1'b0;
    bus.push     = 4'b0000;
    bus.flag_clr = 1'b0;
    step();
    step();
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_gv", 32'(bus.grant_valid), 32'h0);
    chk("rst_gid", 32'(bus.grant_id), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_starve", 32'(bus.starve), 32'h0);
    chk("rst_err", 32'(bus.err_gnt), 32'h0);
    rst = 1'b0;
    step();

    // basic flow on client 2
    bus.push = 4'b0100; step(); bus.push = 4'b0000;
    chk("basic_req", 32'(bus.req), 32'h4);
    gnt_dir = 4'b0100; step(); gnt_dir = 4'b0000;
    chk("basic_gv", 32'(bus.grant_valid), 32'h1);
    chk("basic_gid", 32'(bus.grant_id), 32'h2);
    chk("basic_req_drop", 32'(bus.req), 32'h0);
    step();
    chk("basic_gv_pulse", 32'(bus.grant_valid), 32'h0);
    chk("basic_gid_hold", 32'(bus.grant_id), 32'h2);

    // fill and overflow on client 0
    bus.push = 4'b0001;
    step(); step(); step();
    chk("fill3_full", 32'(bus.full), 32'h0);
    step();
    chk("fill4_full", 32'(bus.full), 32'h1);
    chk("fill4_ovf", 32'(bus.overflow), 32'h0);
    step();
    bus.push = 4'b0000;
    chk("fill5_ovf", 32'(bus.overflow), 32'h1);
    chk("fill5_full", 32'(bus.full), 32'h1);
    gnt_dir = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain0_gv", 32'(bus.grant_valid), 32'h1);
      chk("drain0_gid", 32'(bus.grant_id), 32'h0);
    end
    gnt_dir = 4'b0000;
    chk("drain0_req", 32'(bus.req), 32'h0);
    chk("drain0_err", 32'(bus.err_gnt), 32'h0);
    step();
    chk("drain0_gv_end", 32'(bus.grant_valid), 32'h0);
    bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'h0);

    // simultaneous push and grant at full on client 1
    bus.push = 4'b0010;
    step(); step(); step(); step();
    chk("fill1_full", 32'(bus.full), 32'h2);
    gnt_dir = 4'b0010; step(); bus.push = 4'b0000;
    chk("pg_full", 32'(bus.full), 32'h2);
    chk("pg_ovf", 32'(bus.overflow), 32'h0);
    chk("pg_gv", 32'(bus.grant_valid), 32'h1);
    chk("pg_gid", 32'(bus.grant_id), 32'h1);
    step(); step(); step();
    chk("pg_req_last", 32'(bus.req), 32'h2);
    step(); gnt_dir = 4'b0000;
    chk("pg_drained", 32'(bus.req), 32'h0);

    // illegal grants
    bus.push = 4'b0011; step(); bus.push = 4'b0000;
    chk("ill_req", 32'(bus.req), 32'h3);
    gnt_dir = 4'b0011; step(); gnt_dir = 4'b0000;
    chk("ill_mh_err", 32'(bus.err_gnt), 32'h1);
    chk("ill_mh_gv", 32'(bus.grant_valid), 32'h0);
    chk("ill_mh_req", 32'(bus.req), 32'h3);
    step();
    chk("ill_err_pulse", 32'(bus.err_gnt), 32'h0);
    gnt_dir = 4'b0001; step();
    chk("ill_ok_gid", 32'(bus.grant_id), 32'h0);
    chk("ill_ok_req", 32'(bus.req), 32'h2);
    gnt_dir = 4'b1000; step();
    chk("ill_unreq_err", 32'(bus.err_gnt), 32'h1);
    chk("ill_unreq_gv", 32'(bus.grant_valid), 32'h0);
    chk("ill_unreq_req", 32'(bus.req), 32'h2);
    gnt_dir = 4'b0010; step(); gnt_dir = 4'b0000;
    chk("ill_end_gid", 32'(bus.grant_id), 32'h1);
    chk("ill_end_req", 32'(bus.req), 32'h0);

    // starvation on client 3
    bus.push = 4'b1000; step(); bus.push = 4'b0000;
    chk("stv_req", 32'(bus.req), 32'h8);
    for (int k = 0; k < 15; k++) step();
    chk("stv_15", 32'(bus.starve), 32'h0);
    step();
    chk("stv_16", 32'(bus.starve), 32'h8);
    bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
    chk("stv_clr", 32'(bus.starve), 32'h0);
    step();
    chk("stv_reassert", 32'(bus.starve), 32'h8);
    gnt_dir = 4'b1000; step(); gnt_dir = 4'b0000;
    chk("stv_gid", 32'(bus.grant_id), 32'h3);
    chk("stv_sticky", 32'(bus.starve), 32'h8);
    bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
    chk("stv_clr_final", 32'(bus.starve), 32'h0);

    // integration with round-robin arbiter model
    bus.push = 4'b1111; step(); step(); bus.push = 4'b0000;
    chk("rr_req", 32'(bus.req), 32'hf);
    arb_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_gv", 32'(bus.grant_valid), 32'h1);
      chk("rr_gid", 32'(bus.grant_id), 32'(k % 4));
      chk("rr_err", 32'(bus.err_gnt), 32'h0);
    end
    arb_mode = 1'b0;
    chk("rr_req_end", 32'(bus.req), 32'h0);
    step();
    chk("rr_gv_end", 32'(bus.grant_valid), 32'h0);

    // reset mid-operation discards pending work and the sampled grant
    bus.push = 4'b0001; step(); bus.push = 4'b0000;
    gnt_dir = 4'b0001; rst = 1'b1; step();
    rst = 1'b0; gnt_dir = 4'b0000;
    chk("mid_rst_gv", 32'(bus.grant_valid), 32'h0);
    chk("mid_rst_req", 32'(bus.req), 32'h0);
    chk("mid_rst_gid", 32'(bus.grant_id), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
